// File: rtl/booth_pp_array.sv
// booth_pp_array
//   Radix-4 Booth partial-product generator for one multiplier operand pair.
//   Every multiplier digit is encoded in parallel. The resulting rows (pp plus
//   complement bit) then pass through PIPE valid/ready register stages
//   together with a sideband tag.
//   Row i has weight 4^i. Sign-extension compensation is left to the
//   reduction tree.
//   Optional feature: define BOOTH_PP_UNSIGNED_EN to add the in_unsigned port
//   and one extra row (NPP = N/2+1) for unsigned operands. Without the macro
//   the block is signed-only with NPP = N/2.
module booth_pp_array #(
  parameter int W    = 16,
  parameter int N    = 16,
  parameter int PIPE = 1,
  parameter int TAGW = 4,
`ifdef BOOTH_PP_UNSIGNED_EN
  localparam int NPP = N / 2 + 1
`else
  localparam int NPP = N / 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_y,
  input  logic [N-1:0]          in_x,
  input  logic [TAGW-1:0]       in_tag,
`ifdef BOOTH_PP_UNSIGNED_EN
  input  logic                  in_unsigned,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NPP*(W+1)-1:0]  out_pp,
  output logic [NPP-1:0]        out_cpl,
  output logic [TAGW-1:0]       out_tag
);

  localparam int PW = W + 1;   // width of one row
  localparam int ND = N / 2;   // digits formed from the multiplier itself

  // Reject unsupported parameter combinations at elaboration time.
  if ((N < 2) || (N % 2 != 0)) begin : g_bad_n
    $error("booth_pp_array: N must be even and >= 2");
  end
  if ((PIPE < 0) || (PIPE > 3)) begin : g_bad_pipe
    $error("booth_pp_array: PIPE must be in 0..3");
  end

  // ---------------------------------------------------------------------------
  // Encoder (ahead of stage 0, so every stage carries finished rows)
  // ---------------------------------------------------------------------------
  logic [N:0]        w_xpad;   // multiplier with the implicit x[-1] = 0 appended
  logic              w_uns;
  logic [PW-1:0]     w_ys;     // +y extended to row width
  logic [PW-1:0]     w_y2;     // +2y truncated to row width
  logic [NPP*PW-1:0] w_pp;
  logic [NPP-1:0]    w_cpl;

`ifdef BOOTH_PP_UNSIGNED_EN
  assign w_uns = in_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  assign w_xpad = {in_x, 1'b0};
  assign w_ys   = {(w_uns ? 1'b0 : in_y[W-1]), in_y};
  assign w_y2   = {in_y, 1'b0};

  // One Booth digit -> {cpl, pp}. Negative multiples are sent as the one's
  // complement, and the owed +1 is returned in the cpl bit.
  function automatic logic [PW:0] booth_row(input logic [2:0]    dig,
                                            input logic [PW-1:0] ys,
                                            input logic [PW-1:0] y2);
    logic [PW:0] r;
    case (dig)
      3'b001, 3'b010: r = {1'b0, ys};
      3'b011:         r = {1'b0, y2};
      3'b100:         r = {1'b1, ~y2};
      3'b101, 3'b110: r = {1'b1, ~ys};
      default:        r = '0;            // 000 and 111 encode zero
    endcase
    return r;
  endfunction

  // Encode all digits in parallel. The top row exists only for unsigned operands.
  always_comb begin
    // NOTE: defaults first so that no path through the block can infer a latch.
    w_pp  = '0;
    w_cpl = '0;
    for (int i = 0; i < ND; i++) begin
      {w_cpl[i], w_pp[i*PW +: PW]} = booth_row(w_xpad[2*i +: 3], w_ys, w_y2);
    end
`ifdef BOOTH_PP_UNSIGNED_EN
    // An unsigned x behaves as {2'b00, x}, so its last digit is {0, 0, x[N-1]}.
    if (w_uns) begin
      {w_cpl[ND], w_pp[ND*PW +: PW]} = booth_row({2'b00, in_x[N-1]}, w_ys, w_y2);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  if (PIPE == 0) begin : g_comb
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_pp    = w_pp;
    assign out_cpl   = w_cpl;
    assign out_tag   = in_tag;
  end else begin : g_pipe
    logic [PIPE-1:0]   r_vld;
    logic [NPP*PW-1:0] r_pp  [PIPE];
    logic [NPP-1:0]    r_cpl [PIPE];
    logic [TAGW-1:0]   r_tag [PIPE];

    logic [PIPE-1:0]   w_load;          // stage k may take new contents this cycle
    logic [PIPE-1:0]   w_nvld;          // what stage k would load
    logic [NPP*PW-1:0] w_npp  [PIPE];
    logic [NPP-1:0]    w_ncpl [PIPE];
    logic [TAGW-1:0]   w_ntag [PIPE];

    assign w_nvld[0] = in_valid;
    assign w_npp[0]  = w_pp;
    assign w_ncpl[0] = w_cpl;
    assign w_ntag[0] = in_tag;

    for (genvar k = 1; k < PIPE; k++) begin : g_link
      assign w_nvld[k] = r_vld[k-1];
      assign w_npp[k]  = r_pp[k-1];
      assign w_ncpl[k] = r_cpl[k-1];
      assign w_ntag[k] = r_tag[k-1];
    end

    // Ready ripples back from the output. A stage can load when it is empty or
    // when its current contents leave in the same cycle.
    always_comb begin
      logic v_rdy;
      v_rdy  = out_ready;
      w_load = '0;
      for (int k = PIPE - 1; k >= 0; k--) begin
        v_rdy     = !r_vld[k] || v_rdy;
        w_load[k] = v_rdy;
      end
    end

    // Stage registers. Valid bits follow every load; data changes only when a
    // real operation arrives, so the outputs hold while idle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_vld <= '0;
        // NOTE: data registers are reset too, because zero outputs are required after reset.
        for (int k = 0; k < PIPE; k++) begin
          r_pp[k]  <= '0;
          r_cpl[k] <= '0;
          r_tag[k] <= '0;
        end
      end else begin
        for (int k = 0; k < PIPE; k++) begin
          if (w_load[k]) begin
            r_vld[k] <= w_nvld[k];
            if (w_nvld[k]) begin
              r_pp[k]  <= w_npp[k];
              r_cpl[k] <= w_ncpl[k];
              r_tag[k] <= w_ntag[k];
            end
          end
        end
      end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[PIPE-1];
    assign out_pp    = r_pp[PIPE-1];
    assign out_cpl   = r_cpl[PIPE-1];
    assign out_tag   = r_tag[PIPE-1];
  end

endmodule

// File: tb/tb_booth_pp_array.sv
// tb_booth_pp_array
//   Scoreboard bench for booth_pp_array (W=8, N=8).
//   - Main DUT (PIPE=2): the driver pushes the expected rows for each
//     accepted operation; the monitor pops and compares them on every output
//     transfer. Covers stall hold, reset flush and random traffic.
//   - PIPE=1 copy: must show each cycle's input encode one cycle later.
//   - PIPE=0 copy: must show the combinational encode of its inputs.
//   The reference computes each Booth digit as an integer (-2..+2) and forms
//   the row from |d|*y, complemented when d < 0.
module tb_booth_pp_array;
  localparam int W    = 8;
  localparam int N    = 8;
  localparam int TAGW = 4;
  localparam int PW   = W + 1;
`ifdef BOOTH_PP_UNSIGNED_EN
  localparam int NPP = N / 2 + 1;
`else
  localparam int NPP = N / 2;
`endif

  typedef struct {
    logic [W-1:0]      y;
    logic [N-1:0]      x;
    logic              uns;
    logic [TAGW-1:0]   tag;
    logic [NPP*PW-1:0] pp;
    logic [NPP-1:0]    cpl;
  } op_t;

  logic clk, rst;
  logic in_valid, in_uns, out_ready;
  logic [W-1:0]    in_y;
  logic [N-1:0]    in_x;
  logic [TAGW-1:0] in_tag;

  logic in_ready, out_valid;
  logic [NPP*PW-1:0] out_pp;
  logic [NPP-1:0]    out_cpl;
  logic [TAGW-1:0]   out_tag;

  logic p1_in_ready, p1_out_valid;
  logic [NPP*PW-1:0] p1_pp;
  logic [NPP-1:0]    p1_cpl;
  logic [TAGW-1:0]   p1_tag;

  logic p0_in_ready, p0_out_valid;
  logic [NPP*PW-1:0] p0_pp;
  logic [NPP-1:0]    p0_cpl;
  logic [TAGW-1:0]   p0_tag;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int n_recv   = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  op_t sb[$];

  booth_pp_array #(.W(W), .N(N), .PIPE(2), .TAGW(TAGW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_x(in_x), .in_tag(in_tag),
`ifdef BOOTH_PP_UNSIGNED_EN
    .in_unsigned(in_uns),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pp(out_pp), .out_cpl(out_cpl), .out_tag(out_tag)
  );

  booth_pp_array #(.W(W), .N(N), .PIPE(1), .TAGW(TAGW)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p1_in_ready),
    .in_y(in_y), .in_x(in_x), .in_tag(in_tag),
`ifdef BOOTH_PP_UNSIGNED_EN
    .in_unsigned(in_uns),
`endif
    .out_valid(p1_out_valid), .out_ready(1'b1),
    .out_pp(p1_pp), .out_cpl(p1_cpl), .out_tag(p1_tag)
  );

  booth_pp_array #(.W(W), .N(N), .PIPE(0), .TAGW(TAGW)) u_p0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p0_in_ready),
    .in_y(in_y), .in_x(in_x), .in_tag(in_tag),
`ifdef BOOTH_PP_UNSIGNED_EN
    .in_unsigned(in_uns),
`endif
    .out_valid(p0_out_valid), .out_ready(out_ready),
    .out_pp(p0_pp), .out_cpl(p0_cpl), .out_tag(p0_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rows: digit value d = -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic op_t make_op(input logic [W-1:0] y, input logic [N-1:0] x,
                                  input logic uns, input logic [TAGW-1:0] tag);
    op_t o;
    logic [N+2:0] xp;
    int d;
    longint yv, mag;
    logic [PW-1:0] row;
    o.y = y; o.x = x; o.uns = uns; o.tag = tag; o.pp = '0; o.cpl = '0;
    xp = {2'b00, x, 1'b0};
    yv = uns ? longint'(y) : longint'($signed(y));
    for (int i = 0; i < NPP; i++) begin
      if (i < N / 2 || uns) begin
        d   = -2 * int'(xp[2*i+2]) + int'(xp[2*i+1]) + int'(xp[2*i]);
        mag = longint'(d < 0 ? -d : d) * yv;
        row = mag[PW-1:0];
        if (d < 0) begin
          row = ~row;
          o.cpl[i] = 1'b1;
        end
        o.pp[i*PW +: PW] = row;
      end
    end
    return o;
  endfunction

  // Operation with rows given literally (row0 in the low bits).
  function automatic op_t lit_op(input logic [W-1:0] y, input logic [N-1:0] x, input logic uns,
                                 input logic [TAGW-1:0] tag, input logic [5*PW-1:0] rows,
                                 input logic [4:0] cpl);
    op_t o;
    o.y = y; o.x = x; o.uns = uns; o.tag = tag;
    o.pp  = rows[NPP*PW-1:0];
    o.cpl = cpl[NPP-1:0];
    return o;
  endfunction

  // Value of the emitted rows: sum of row*4^i plus cpl*4^i.
  function automatic longint row_sum(input logic [NPP*PW-1:0] pp, input logic [NPP-1:0] cpl,
                                     input logic uns);
    longint s, v;
    s = 0;
    for (int i = 0; i < NPP; i++) begin
      v = longint'(pp[i*PW +: PW]);
      if (uns ? cpl[i] : pp[i*PW + PW - 1]) v = v - (longint'(1) << PW);
      s = s + (v + longint'(cpl[i])) * (longint'(1) << (2 * i));
    end
    return s;
  endfunction

  function automatic longint product(input op_t o);
    if (o.uns) return longint'(o.y) * longint'(o.x);
    return longint'($signed(o.y)) * longint'($signed(o.x));
  endfunction

  // Present an op at a falling edge and hold it until accepted (bounded).
  task automatic send(input op_t o);
    bit done;
    done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_y = o.y; in_x = o.x; in_uns = o.uns; in_tag = o.tag;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (in_ready) begin
        sb.push_back(o);
        n_sent++;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: tag %0h never accepted", o.tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Downstream ready pattern, changed only at falling edges.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop/compare, stall stability, PIPE=1 and PIPE=0 copies.
  initial begin : monitor
    op_t e, m;
    logic hold_p, prev_rst, prev_v, prev_u;
    logic [NPP*PW-1:0] hold_pp;
    logic [NPP-1:0]    hold_cpl;
    logic [TAGW-1:0]   hold_tag, prev_t;
    logic [W-1:0]      prev_y;
    logic [N-1:0]      prev_x;
    hold_p = 0; prev_rst = 0; prev_v = 0; prev_u = 0;
    hold_pp = '0; hold_cpl = '0; hold_tag = '0; prev_t = '0; prev_y = '0; prev_x = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst && hold_p) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_pp", out_pp, hold_pp);
        check("hold_cpl", out_cpl, hold_cpl);
        check("hold_tag", out_tag, hold_tag);
      end
      hold_p = rst && out_valid && !out_ready;
      hold_pp = out_pp; hold_cpl = out_cpl; hold_tag = out_tag;
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_output: tag %0h emitted with nothing outstanding", out_tag);
        end else begin
          e = sb.pop_front();
          n_recv++;
          check("out_tag", out_tag, e.tag);
          check("out_pp", out_pp, e.pp);
          check("out_cpl", out_cpl, e.cpl);
          check("row_sum", row_sum(out_pp, out_cpl, e.uns), product(e));
        end
      end
      if (rst && prev_rst) begin
        check("p1_in_ready", p1_in_ready, 1'b1);
        check("p1_valid", p1_out_valid, prev_v);
        if (prev_v) begin
          m = make_op(prev_y, prev_x, prev_u, prev_t);
          check("p1_pp", p1_pp, m.pp);
          check("p1_cpl", p1_cpl, m.cpl);
          check("p1_tag", p1_tag, prev_t);
        end
      end
      prev_rst = rst; prev_v = in_valid; prev_y = in_y; prev_x = in_x;
      prev_u = in_uns; prev_t = in_tag;
      m = make_op(in_y, in_x, in_uns, in_tag);
      check("p0_valid", p0_out_valid, in_valid);
      check("p0_in_ready", p0_in_ready, out_ready);
      check("p0_pp", p0_pp, m.pp);
      check("p0_cpl", p0_cpl, m.cpl);
      check("p0_tag", p0_tag, in_tag);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic u;
    logic [W-1:0] y;
    rst = 1'b0; in_valid = 1'b0; in_y = '0; in_x = '0; in_tag = '0; in_uns = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_pp", out_pp, '0);
    check("rst_out_cpl", out_cpl, '0);
    check("rst_out_tag", out_tag, '0);
    @(negedge clk);
    #2 rst = 1'b1;

    // y=03, x=01, plus latency through an empty two-stage pipe
    send(lit_op(8'h03, 8'h01, 1'b0, 4'h1, {9'h000, 9'h000, 9'h000, 9'h000, 9'h003}, 5'b00000));
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("lat_early", out_valid, 1'b0);
    @(negedge clk);
    #1 check("lat_out", out_valid, 1'b1);
    check("lat_tag", out_tag, 4'h1);

    // digit 100 (-2y), then digits 110 and 001
    send(lit_op(8'h05, 8'h80, 1'b0, 4'h2, {9'h000, 9'h1F5, 9'h000, 9'h000, 9'h000}, 5'b01000));
    send(lit_op(8'h81, 8'h03, 1'b0, 4'h3, {9'h000, 9'h000, 9'h000, 9'h181, 9'h07E}, 5'b00001));
`ifdef BOOTH_PP_UNSIGNED_EN
    send(lit_op(8'hFF, 8'hFF, 1'b1, 4'h4, {9'h0FF, 9'h000, 9'h000, 9'h000, 9'h100}, 5'b00001));
`endif
    idle(4);

    // Full stall: two ops fill the pipe, the third must wait
    ready_mode = 2;
    idle(2);
    send(make_op(8'h11, 8'h22, 1'b0, 4'h1));
    send(make_op(8'hA5, 8'h5A, 1'b0, 4'h2));
    @(negedge clk);
    in_valid = 1'b1; in_y = 8'h7F; in_x = 8'h80; in_tag = 4'h3; in_uns = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 check("stall_in_ready", in_ready, 1'b0);
      if (c == 0) check("stall_head_tag", out_tag, 4'h1);
      @(negedge clk);
    end
    ready_mode = 0;
    send(make_op(8'h7F, 8'h80, 1'b0, 4'h3));
    idle(6);

    // Reset while an op is held at the output
    ready_mode = 2;
    send(make_op(8'h12, 8'h34, 1'b0, 4'hA));
    idle(1);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
    end
    check("rst_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_pp", out_pp, '0);
    check("rst_mid_cpl", out_cpl, '0);
    check("rst_mid_tag", out_tag, '0);
    check("rst_mid_ready", in_ready, 1'b1);
    n_sent = n_sent - sb.size();
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    ready_mode = 0;
    send(lit_op(8'h03, 8'h01, 1'b0, 4'h5, {9'h000, 9'h000, 9'h000, 9'h000, 9'h003}, 5'b00000));
    idle(3);

    // Random sweep with random back-pressure and gaps
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      u = 1'b0;
`ifdef BOOTH_PP_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`endif
      case ($urandom_range(0, 5))
        0:       y = 8'h80;
        1:       y = 8'h7F;
        2:       y = 8'hFF;
        default: y = W'($urandom);
      endcase
      send(make_op(y, N'($urandom), u, TAGW'(n)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    ready_mode = 0;
    for (int c = 0; c < 200 && sb.size() > 0; c++) @(negedge clk);
    idle(2);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("sent_vs_recv", 64'(n_recv), 64'(n_sent));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
